serial_mode_sequencer: RTL and testbench
========================================

# serial_mode_sequencer

Sequences the serial-mode MAC engine (data loader + PE in accumulate mode) across NUM_OUT consecutive output positions. For each output it clears the engine, enables it at the current feature base address, waits for its done flag, then writes the 8-bit result back into the shared 64-entry scratch memory. It owns the single memory port and multiplexes it between engine operand reads and result write-back. It sits between the top-level control FSM and one serial-mode engine instance.

## Interface
- NUM_OUT, 4: output positions per job (1..64)
- FEAT_STRIDE, 8'd1: feature base-address increment between outputs
- RESULT_BASE, 6'd48: memory address of the first result
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  job request; accepted only in IDLE
- abort  in  1  cancel current job; honoured in CLR, RUN and WB
- feature_base0  in  8  feature base address for output 0, sampled on accepted start
- busy  out  1  high from the cycle after start acceptance until return to IDLE
- done  out  1  one-cycle pulse at normal job completion
- out_idx  out  6  index of the output currently being computed
- eng_en  out  1  engine enable
- eng_rst  out  1  engine reset (loader counters + PE accumulator)
- eng_baseaddr  out  8  feature base address driven to engine
- eng_addr  in  6  engine's requested memory address
- eng_done  in  1  engine completion flag
- eng_out  in  8  engine result (PE serial-mode output)
- mem_addr  out  6  shared memory address
- mem_we  out  1  memory write enable
- mem_d  out  8  memory write data

## Operation
- States: IDLE, CLR, RUN, WB, FIN.
- IDLE: start=1 -> latch base <= feature_base0, idx <= 0 -> CLR. start is ignored in every other state.
- CLR (1 cycle): eng_rst=1, eng_en=0 -> RUN. eng_done is ignored here.
- RUN: eng_en=1, mem_addr=eng_addr, mem_we=0. On eng_done=1: result_r <= eng_out -> WB.
- WB (1 cycle): mem_we=1, mem_addr=RESULT_BASE+idx (mod 64), mem_d=result_r, eng_en=0. If idx==NUM_OUT-1 -> FIN. Otherwise idx <= idx+1, base <= base+FEAT_STRIDE (mod 256) -> CLR.
- FIN (1 cycle): done=1 -> IDLE.
- abort=1 in CLR, RUN or WB -> IDLE next cycle. No write-back, no done pulse, eng_rst=1 in that same cycle. abort wins over eng_done and over the WB write (mem_we forced 0).
- eng_rst = rst OR state==CLR OR abort-taken. The engine is therefore held in reset while the sequencer is in reset.
- eng_baseaddr = base register, stable throughout CLR/RUN.
- Reset values: state IDLE, busy 0, done 0, eng_en 0, eng_rst 1 (during rst), out_idx 0, base 0, result_r 0, mem_addr 0, mem_we 0, mem_d 0.
- busy = state != IDLE.
- In IDLE and FIN: mem_addr=0, mem_we=0.

## Timing
- Start accepted at edge T0. CLR in cycle T0+1, RUN from T0+2.
- Engine taking E cycles in RUN gives a per-output latency of E+2 cycles (CLR + RUN + WB).
- Job latency = NUM_OUT*(E+2)+1 cycles from acceptance to the done pulse.
- eng_done is sampled at the clock edge; result_r is captured on that same edge.
- The write occurs one cycle later, with no combinational path from eng_done to mem_we.
- Reset asserted mid-job: IDLE on the next edge; no done; any pending write is discarded.
- NUM_OUT=1: WB goes directly to FIN.
- Address wrap: RESULT_BASE+idx uses 6-bit wrap; base uses 8-bit wrap. Neither is flagged.

## Structure
- Shared package serial_pkg holds: state enum (IDLE/CLR/RUN/WB/FIN), ADDR_W=6, DATA_W=8, FEAT_W=8.
- One natural sub-module, serial_mem_mux: combinational port mux selecting engine read vs. write-back by state. The FSM, counters and registers stay in the top module.

## Test plan
- NUM_OUT=4, feature_base0=8'h10, engine model with E=9 cycles and results 8'h11,22,33,44 -> writes at addresses 48..51 with those data; eng_baseaddr 10,11,12,13; done pulse exactly 45 cycles after acceptance.
- start held high through the whole job -> only one job runs; a new job starts only on the edge after the done cycle returns to IDLE.
- abort in RUN of output 2 (eng_done asserted in the same cycle) -> no write to address 50, eng_rst=1 that cycle, IDLE next cycle, no done pulse.
- rst for one cycle in the middle of WB -> mem_we=0 that cycle; all outputs at reset values; eng_rst=1.
- RESULT_BASE=6'd62, NUM_OUT=3, feature_base0=8'hFF -> writes to addresses 62, 63, 0; base sequence FF, 00, 01.
- eng_done pulsed during CLR -> ignored; RUN waits for the next eng_done.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and widths for the serial-mode MAC sequencer.
package serial_pkg;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 8;
   localparam int FEAT_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      RUN,
      WB,
      FIN
   } state_t;

endpackage

// File: rtl/serial_mem_mux.sv
// Single scratch-memory port shared between engine operand reads and result write-back.
module serial_mem_mux
   import serial_pkg::*;
(
   input  logic              sel_eng,
   input  logic              sel_wb,
   input  logic [ADDR_W-1:0] eng_addr,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_d
);

   always_comb begin
      mem_addr = '0;
      mem_we   = 1'b0;
      mem_d    = '0;
      if (sel_wb) begin
         mem_addr = wb_addr;
         mem_we   = 1'b1;
         mem_d    = wb_data;
      end else if (sel_eng) begin
         mem_addr = eng_addr;
      end
   end

endmodule

// File: rtl/serial_mode_sequencer.sv
// Steps one serial-mode engine through NUM_OUT output positions: clear, run, write back.
module serial_mode_sequencer
   import serial_pkg::*;
#(
   parameter int                NUM_OUT     = 4,
   parameter logic [FEAT_W-1:0] FEAT_STRIDE = 8'd1,
   parameter logic [ADDR_W-1:0] RESULT_BASE = 6'd48
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [FEAT_W-1:0] feature_base0,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] out_idx,
   output logic              eng_en,
   output logic              eng_rst,
   output logic [FEAT_W-1:0] eng_baseaddr,
   input  logic [ADDR_W-1:0] eng_addr,
   input  logic              eng_done,
   input  logic [DATA_W-1:0] eng_out,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_d
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_OUT - 1);

   state_t              state;
   logic [ADDR_W-1:0]   idx;
   logic [FEAT_W-1:0]   base;
   logic [DATA_W-1:0]   result_r;
   logic                abort_taken;
   logic [ADDR_W-1:0]   wb_addr;

   assign abort_taken = abort && (state == CLR || state == RUN || state == WB);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         base     <= '0;
         result_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  base  <= feature_base0;
                  idx   <= '0;
                  state <= CLR;
               end
            end
            CLR: state <= abort ? IDLE : RUN;
            RUN: begin
               if (abort) begin
                  state <= IDLE;
               end else if (eng_done) begin
                  result_r <= eng_out;
                  state    <= WB;
               end
            end
            WB: begin
               if (abort) begin
                  state <= IDLE;
               end else if (idx == LAST_IDX) begin
                  state <= FIN;
               end else begin
                  idx   <= idx + 1'b1;
                  base  <= base + FEAT_STRIDE;
                  state <= CLR;
               end
            end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy         = (state != IDLE);
   assign done         = (state == FIN);
   assign eng_en       = (state == RUN);
   assign eng_rst      = rst || (state == CLR) || abort_taken;
   assign out_idx      = idx;
   assign eng_baseaddr = base;
   assign wb_addr      = RESULT_BASE + idx;

   // Reset and abort both squash the write in the WB cycle itself.
   serial_mem_mux u_mem_mux (
      .sel_eng  (state == RUN),
      .sel_wb   ((state == WB) && !abort && !rst),
      .eng_addr (eng_addr),
      .wb_addr  (wb_addr),
      .wb_data  (result_r),
      .mem_addr (mem_addr),
      .mem_we   (mem_we),
      .mem_d    (mem_d)
   );

endmodule

// File: tb/tb_serial_mode_sequencer.sv
// Directed bench for serial_mode_sequencer: default instance plus a wrap-around instance.
module tb_serial_mode_sequencer;

   localparam int E = 9;

   logic       clk;
   logic       rst;
   logic       start [2];
   logic       abort [2];
   logic [7:0] fb0 [2];
   logic       busy [2];
   logic       done [2];
   logic [5:0] out_idx [2];
   logic       eng_en [2];
   logic       eng_rst [2];
   logic [7:0] eng_baseaddr [2];
   logic [5:0] eng_addr [2];
   logic       eng_done [2];
   logic [7:0] eng_out [2];
   logic [5:0] mem_addr [2];
   logic       mem_we [2];
   logic [7:0] mem_d [2];
   logic       force_done [2];

   int cnt [2];
   int vectors;
   int miscompares;
   int done_cnt0;
   int done_cnt1;
   logic [5:0] wa0 [$];
   logic [7:0] wd0 [$];
   logic [7:0] bq0 [$];
   logic [5:0] wa1 [$];
   logic [7:0] wd1 [$];
   logic [7:0] bq1 [$];

   serial_mode_sequencer dut_a (
      .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .feature_base0(fb0[0]),
      .busy(busy[0]), .done(done[0]), .out_idx(out_idx[0]), .eng_en(eng_en[0]),
      .eng_rst(eng_rst[0]), .eng_baseaddr(eng_baseaddr[0]), .eng_addr(eng_addr[0]),
      .eng_done(eng_done[0]), .eng_out(eng_out[0]), .mem_addr(mem_addr[0]),
      .mem_we(mem_we[0]), .mem_d(mem_d[0])
   );

   serial_mode_sequencer #(.NUM_OUT(3), .FEAT_STRIDE(8'd1), .RESULT_BASE(6'd62)) dut_b (
      .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .feature_base0(fb0[1]),
      .busy(busy[1]), .done(done[1]), .out_idx(out_idx[1]), .eng_en(eng_en[1]),
      .eng_rst(eng_rst[1]), .eng_baseaddr(eng_baseaddr[1]), .eng_addr(eng_addr[1]),
      .eng_done(eng_done[1]), .eng_out(eng_out[1]), .mem_addr(mem_addr[1]),
      .mem_we(mem_we[1]), .mem_d(mem_d[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Engine model: done on the E-th RUN cycle after a clear; result 11h*(idx+1).
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (eng_rst[i]) cnt[i] <= 0;
         else if (eng_en[i]) cnt[i] <= cnt[i] + 1;
      end
   end

   assign eng_done[0] = force_done[0] | (eng_en[0] && cnt[0] == E - 1);
   assign eng_done[1] = force_done[1] | (eng_en[1] && cnt[1] == E - 1);
   assign eng_addr[0] = 6'(cnt[0]) + 6'd5;
   assign eng_addr[1] = 6'(cnt[1]) + 6'd5;
   assign eng_out[0]  = 8'(8'h11 * (out_idx[0] + 6'd1));
   assign eng_out[1]  = 8'(8'h11 * (out_idx[1] + 6'd1));

   always @(negedge clk) begin
      if (mem_we[0]) begin wa0.push_back(mem_addr[0]); wd0.push_back(mem_d[0]); end
      if (mem_we[1]) begin wa1.push_back(mem_addr[1]); wd1.push_back(mem_d[1]); end
      if (eng_rst[0] && busy[0] && !rst && !abort[0]) bq0.push_back(eng_baseaddr[0]);
      if (eng_rst[1] && busy[1] && !rst && !abort[1]) bq1.push_back(eng_baseaddr[1]);
      if (done[0]) done_cnt0++;
      if (done[1]) done_cnt1++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int n;
      int done_n;
      int r;
      int d0;
      logic [5:0] ea [4];
      logic [7:0] ed [4];
      logic [7:0] eb [4];

      vectors = 0; miscompares = 0; done_cnt0 = 0; done_cnt1 = 0;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         start[i] = 1'b0; abort[i] = 1'b0; fb0[i] = 8'h00; force_done[i] = 1'b0;
      end

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy[0]), 0);
      chk("rst_done", 32'(done[0]), 0);
      chk("rst_eng_en", 32'(eng_en[0]), 0);
      chk("rst_eng_rst", 32'(eng_rst[0]), 1);
      chk("rst_out_idx", 32'(out_idx[0]), 0);
      chk("rst_base", 32'(eng_baseaddr[0]), 0);
      chk("rst_mem_we", 32'(mem_we[0]), 0);
      chk("rst_mem_addr", 32'(mem_addr[0]), 0);
      chk("rst_mem_d", 32'(mem_d[0]), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_eng_rst", 32'(eng_rst[0]), 0);

      // Full job, start held high throughout
      start[0] = 1'b1; fb0[0] = 8'h10;
      n = 0; done_n = 0;
      while (done_n == 0 && n < 200) begin
         @(posedge clk); @(negedge clk);
         n++;
         if (n == 1) begin
            chk("clr_busy", 32'(busy[0]), 1);
            chk("clr_eng_rst", 32'(eng_rst[0]), 1);
            chk("clr_eng_en", 32'(eng_en[0]), 0);
         end
         if (n == 5) begin
            chk("run_eng_en", 32'(eng_en[0]), 1);
            chk("run_mem_addr", 32'(mem_addr[0]), 32'(eng_addr[0]));
            chk("run_mem_we", 32'(mem_we[0]), 0);
         end
         if (done[0]) done_n = n;
      end
      chk("job_latency", done_n, 45);
      @(negedge clk);
      chk("post_done_idle", 32'(busy[0]), 0);
      @(negedge clk);
      chk("restart_busy", 32'(busy[0]), 1);
      start[0] = 1'b0;
      #1;
      ea = '{6'd48, 6'd49, 6'd50, 6'd51};
      ed = '{8'h11, 8'h22, 8'h33, 8'h44};
      eb = '{8'h10, 8'h11, 8'h12, 8'h13};
      chk("job1_nwrites", wa0.size(), 4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("job1_waddr%0d", k), (wa0.size() > k) ? 32'(wa0[k]) : 32'hDEAD, 32'(ea[k]));
         chk($sformatf("job1_wdata%0d", k), (wd0.size() > k) ? 32'(wd0[k]) : 32'hDEAD, 32'(ed[k]));
         chk($sformatf("job1_base%0d", k), (bq0.size() > k) ? 32'(bq0[k]) : 32'hDEAD, 32'(eb[k]));
      end
      chk("job1_done_cnt", done_cnt0, 1);
      wa0.delete(); wd0.delete(); bq0.delete();

      // Abort during RUN of output 2, with eng_done in the same cycle
      n = 0;
      while (!(out_idx[0] == 6'd2 && eng_en[0]) && n < 200) begin
         @(negedge clk); n++;
      end
      chk("abort_reach_run2", 32'(out_idx[0] == 6'd2 && eng_en[0]), 1);
      d0 = done_cnt0;
      abort[0] = 1'b1; force_done[0] = 1'b1;
      #1;
      chk("abort_eng_rst", 32'(eng_rst[0]), 1);
      chk("abort_mem_we", 32'(mem_we[0]), 0);
      @(negedge clk);
      abort[0] = 1'b0; force_done[0] = 1'b0;
      chk("abort_idle", 32'(busy[0]), 0);
      repeat (3) @(negedge clk);
      chk("abort_nwrites", wa0.size(), 2);
      chk("abort_no_done", done_cnt0 - d0, 0);

      // Reset during WB of output 0
      wa0.delete(); wd0.delete(); bq0.delete();
      start[0] = 1'b1; fb0[0] = 8'h20;
      @(negedge clk);
      start[0] = 1'b0;
      n = 0;
      while (!(eng_en[0] && eng_done[0]) && n < 100) begin
         @(negedge clk); n++;
      end
      @(posedge clk); #1;
      chk("wb_pre_we", 32'(mem_we[0]), 1);
      rst = 1'b1; #1;
      chk("wb_rst_we", 32'(mem_we[0]), 0);
      chk("wb_rst_eng_rst", 32'(eng_rst[0]), 1);
      @(posedge clk); @(negedge clk);
      chk("wbrst_busy", 32'(busy[0]), 0);
      chk("wbrst_done", 32'(done[0]), 0);
      chk("wbrst_eng_en", 32'(eng_en[0]), 0);
      chk("wbrst_idx", 32'(out_idx[0]), 0);
      chk("wbrst_base", 32'(eng_baseaddr[0]), 0);
      chk("wbrst_mem_addr", 32'(mem_addr[0]), 0);
      rst = 1'b0;
      #1;
      chk("wbrst_nwrites", wa0.size(), 0);

      // Wrap-around instance: RESULT_BASE 62, NUM_OUT 3, base FF
      @(negedge clk);
      start[1] = 1'b1; fb0[1] = 8'hFF;
      n = 0; done_n = 0;
      while (done_n == 0 && n < 200) begin
         @(posedge clk); @(negedge clk);
         start[1] = 1'b0;
         n++;
         if (done[1]) done_n = n;
      end
      chk("wrap_latency", done_n, 34);
      ea = '{6'd62, 6'd63, 6'd0, 6'd0};
      ed = '{8'h11, 8'h22, 8'h33, 8'h00};
      eb = '{8'hFF, 8'h00, 8'h01, 8'h00};
      chk("wrap_nwrites", wa1.size(), 3);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("wrap_waddr%0d", k), (wa1.size() > k) ? 32'(wa1[k]) : 32'hDEAD, 32'(ea[k]));
         chk($sformatf("wrap_wdata%0d", k), (wd1.size() > k) ? 32'(wd1[k]) : 32'hDEAD, 32'(ed[k]));
         chk($sformatf("wrap_base%0d", k), (bq1.size() > k) ? 32'(bq1[k]) : 32'hDEAD, 32'(eb[k]));
      end

      // eng_done during CLR is ignored
      wa0.delete(); wd0.delete(); bq0.delete();
      @(negedge clk);
      start[0] = 1'b1; fb0[0] = 8'h30;
      @(negedge clk);
      start[0] = 1'b0; force_done[0] = 1'b1;
      #1;
      chk("clrdone_eng_rst", 32'(eng_rst[0]), 1);
      @(negedge clk);
      force_done[0] = 1'b0;
      chk("clrdone_in_run", 32'(eng_en[0]), 1);
      r = 1;
      while (r < 100) begin
         @(negedge clk);
         if (!eng_en[0]) break;
         r++;
      end
      chk("clrdone_run_len", r, E);
      chk("clrdone_wb_we", 32'(mem_we[0]), 1);
      d0 = done_cnt0;
      n = 0;
      while (busy[0] && n < 200) begin
         @(negedge clk); n++;
      end
      chk("clrdone_done_cnt", done_cnt0 - d0, 1);
      chk("clrdone_waddr0", (wa0.size() > 0) ? 32'(wa0[0]) : 32'hDEAD, 48);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
